sap_ram_ctrl: RTL and testbench

Parametrised successor to the SAP-U RAM/MAR block: a 2**ADDR_W x DATA_W static RAM with a memory address register (MAR), a run-mode bus write path and a program-mode loader. The loader debounces the front-panel push button, performs exactly one write per press, and hands off cleanly when the mode changes. The block sits on the 8-bit system bus between the control unit (MAR load/increment, RAM-in, RAM-out strobes) and the front-panel dipswitches and push button.

---
 rtl/sap_pkg.sv | 22 ++
 rtl/sap_ram_ctrl_btn_debounce.sv | 99 +++++++++
 rtl/sap_ram_ctrl.sv | 80 ++++++++
 tb/tb_sap_ram_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP RAM/MAR block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sap_pkg;

    // Program-mode loader states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } ld_state_t;

    // Address source select
    localparam logic ADDR_SRC_DIP = 1'b0;
    localparam logic ADDR_SRC_MAR = 1'b1;

    // Operating mode
    localparam logic MODE_PROG = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/sap_ram_ctrl_btn_debounce.sv
// Push-button synchroniser + debounce FSM producing one write pulse per accepted press.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES cycles in PRESS, then a single WRITE cycle.
// Backpressure: none; enable low forces IDLE and suppresses the pulse immediately.
module btn_debounce
    import sap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic enable,
    input  logic push_button,
    output logic write_pulse
);

    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             btn_s;
    ld_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign btn_s = sync_q[1];

    // Two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], push_button};
        end
    end

    // Loader state and debounce counter registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: count stable samples on press and on release
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_pulse = 1'b0;
        if (!enable) begin
            // Leaving program mode: abandon any press, never write
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (btn_s) begin
                        state_d = PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end
                PRESS: begin
                    if (!btn_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WRITE: begin
                    write_pulse = 1'b1;
                    state_d     = RELEASE;
                    cnt_d       = '0;
                end
                RELEASE: begin
                    if (btn_s) begin
                        // Bounce back high: release must be stable from scratch
                        cnt_d = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sap_ram_ctrl.sv
// SAP RAM + MAR with run-mode bus writes and a debounced front-panel program loader.
// Latency: writes land on the clock edge; reads are combinational from the current address.
// Backpressure: none; strobes are sampled every edge, the loader ignores ram_in_n.
module sap_ram_ctrl
    import sap_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              prog_mode,
    input  logic              addr_select,
    input  logic [ADDR_W-1:0] dipswitch_addr,
    input  logic [DATA_W-1:0] dipswitch_data,
    input  logic              push_button,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_clr,
    input  logic              load_mar_n,
    input  logic              inc_mar_n,
    input  logic              ram_in_n,
    input  logic              bus_enable_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mar_q,
    output logic              prog_write
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              run_we;
    logic              write_pulse;
    logic              unused_bus_hi;

    // Only the low bus bits feed the MAR
    assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];

    assign addr   = (addr_select == ADDR_SRC_DIP) ? dipswitch_addr : mar_q;
    assign run_we = clr_n && (prog_mode == MODE_RUN) && !ram_in_n;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk         (clk),
        .clr_n       (clr_n),
        .enable      (prog_mode == MODE_PROG),
        .push_button (push_button),
        .write_pulse (write_pulse)
    );

    // MAR: clear beats load beats increment; increment wraps naturally
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar_q <= '0;
        end else if (mar_clr) begin
            mar_q <= '0;
        end else if (!load_mar_n) begin
            mar_q <= bus_in[ADDR_W-1:0];
        end else if (!inc_mar_n) begin
            mar_q <= mar_q + ADDR_W'(1);
        end
    end

    // Memory array: uninitialised, written at the pre-edge address
    always_ff @(posedge clk) begin
        if (run_we) begin
            mem[addr] <= bus_in;
        end else if (write_pulse) begin
            mem[addr] <= dipswitch_data;
        end
    end

    assign bus_oe     = ~bus_enable_n;
    assign bus_out    = bus_enable_n ? '0 : mem[addr];
    assign prog_write = write_pulse;

endmodule

// File: tb/tb_sap_ram_ctrl.sv
module tb_sap_ram_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEB    = 4;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              prog_mode;
    logic              addr_select;
    logic [ADDR_W-1:0] dipswitch_addr;
    logic [DATA_W-1:0] dipswitch_data;
    logic              push_button;
    logic [DATA_W-1:0] bus_in;
    logic              mar_clr;
    logic              load_mar_n;
    logic              inc_mar_n;
    logic              ram_in_n;
    logic              bus_enable_n;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [ADDR_W-1:0] mar_q;
    logic              prog_write;

    sap_ram_ctrl #(
        .DATA_W          (DATA_W),
        .ADDR_W          (ADDR_W),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .prog_mode      (prog_mode),
        .addr_select    (addr_select),
        .dipswitch_addr (dipswitch_addr),
        .dipswitch_data (dipswitch_data),
        .push_button    (push_button),
        .bus_in         (bus_in),
        .mar_clr        (mar_clr),
        .load_mar_n     (load_mar_n),
        .inc_mar_n      (inc_mar_n),
        .ram_in_n       (ram_in_n),
        .bus_enable_n   (bus_enable_n),
        .bus_out        (bus_out),
        .bus_oe         (bus_oe),
        .mar_q          (mar_q),
        .prog_write     (prog_write)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int pulse_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Count program-write pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (prog_write) begin
            pulses    = pulses + 1;
            pulse_cyc = cyc;
        end
    end

    typedef struct {
        logic       clr;
        logic       ld_n;
        logic       inc_n;
        logic       wr_n;
        logic       en_n;
        logic       asel;
        logic [3:0] dip_a;
        logic [7:0] din;
        logic [3:0] e_mar;
        logic       e_oe;
        logic [7:0] e_bus;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] mar;
        logic       oe;
        logic [7:0] bus;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    function automatic vec_t mk(input logic clr, input logic ld_n, input logic inc_n,
                                input logic wr_n, input logic en_n, input logic asel,
                                input logic [3:0] dip_a, input logic [7:0] din,
                                input logic [3:0] e_mar, input logic e_oe,
                                input logic [7:0] e_bus);
        vec_t v;
        v.clr = clr; v.ld_n = ld_n; v.inc_n = inc_n; v.wr_n = wr_n; v.en_n = en_n;
        v.asel = asel; v.dip_a = dip_a; v.din = din;
        v.e_mar = e_mar; v.e_oe = e_oe; v.e_bus = e_bus;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        mar_clr = 1'b0; load_mar_n = 1'b1; inc_mar_n = 1'b1;
        ram_in_n = 1'b1; bus_enable_n = 1'b1;
    endtask

    task automatic btn(input logic v, input int n);
        push_button = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic readback(input string name, input logic [3:0] a, input logic [7:0] req);
        addr_select    = 1'b0;
        dipswitch_addr = a;
        bus_enable_n   = 1'b0;
        #1;
        chk(name, bus_out, req);
        bus_enable_n   = 1'b1;
    endtask

    initial begin
        int p0;
        int start;
        exp_t e;

        // Run-mode vectors: clr ld inc wr en asel dip din | mar oe bus
        vecs[0]  = mk(0, 0, 1, 1, 1, 1, 4'h0, 8'hF5, 4'h5, 0, 8'h00); // load ignores upper bits
        vecs[1]  = mk(0, 1, 1, 0, 1, 1, 4'h0, 8'hA7, 4'h5, 0, 8'h00); // mem[5]=A7
        vecs[2]  = mk(0, 1, 1, 1, 0, 1, 4'h0, 8'h00, 4'h5, 1, 8'hA7); // read mem[5]
        vecs[3]  = mk(0, 0, 1, 1, 1, 1, 4'h0, 8'hAF, 4'hF, 0, 8'h00); // MAR=F
        vecs[4]  = mk(0, 1, 0, 0, 1, 1, 4'h0, 8'h5A, 4'h0, 0, 8'h00); // write F, wrap to 0
        vecs[5]  = mk(0, 0, 1, 1, 0, 1, 4'h0, 8'h0F, 4'hF, 1, 8'h5A); // pre-edge addr used
        vecs[6]  = mk(0, 0, 0, 1, 1, 1, 4'h0, 8'h03, 4'h3, 0, 8'h00); // load beats inc
        vecs[7]  = mk(1, 0, 0, 1, 1, 1, 4'h0, 8'h07, 4'h0, 0, 8'h00); // clear beats all
        vecs[8]  = mk(0, 0, 1, 1, 0, 1, 4'h0, 8'h05, 4'h5, 1, 8'hA7); // bus follows new MAR
        vecs[9]  = mk(0, 1, 1, 0, 0, 1, 4'h0, 8'hC3, 4'h5, 1, 8'hC3); // write-then-read
        vecs[10] = mk(0, 1, 0, 1, 1, 1, 4'h0, 8'h00, 4'h6, 0, 8'h00); // inc 5->6
        vecs[11] = mk(0, 1, 1, 1, 0, 0, 4'hF, 8'h00, 4'h6, 1, 8'h5A); // dipswitch address
        vecs[12] = mk(0, 1, 1, 0, 1, 0, 4'h6, 8'hE6, 4'h6, 0, 8'h00); // mem[6]=E6 via dip

        // Reset state
        clr_n = 1'b0; prog_mode = 1'b1; addr_select = 1'b1;
        dipswitch_addr = '0; dipswitch_data = '0; push_button = 1'b0; bus_in = '0;
        idle_strobes();
        #12;
        chk("rst_mar", mar_q, 4'h0);
        chk("rst_prog_write", prog_write, 1'b0);
        chk("rst_oe", bus_oe, 1'b0);
        chk("rst_bus", bus_out, 8'h00);
        bus_enable_n = 1'b0;
        #1;
        chk("rst_oe_follow", bus_oe, 1'b1);
        bus_enable_n = 1'b1;
        tick();
        clr_n = 1'b1;
        tick();

        // Table-driven run-mode sequence through a scoreboard
        for (int i = 0; i < 13; i++) begin
            mar_clr        = vecs[i].clr;
            load_mar_n     = vecs[i].ld_n;
            inc_mar_n      = vecs[i].inc_n;
            ram_in_n       = vecs[i].wr_n;
            bus_enable_n   = vecs[i].en_n;
            addr_select    = vecs[i].asel;
            dipswitch_addr = vecs[i].dip_a;
            bus_in         = vecs[i].din;
            e.idx = i; e.mar = vecs[i].e_mar; e.oe = vecs[i].e_oe; e.bus = vecs[i].e_bus;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            chk($sformatf("vec%0d_mar", e.idx), mar_q, e.mar);
            chk($sformatf("vec%0d_oe", e.idx), bus_oe, e.oe);
            chk($sformatf("vec%0d_bus", e.idx), bus_out, e.bus);
        end
        idle_strobes();
        bus_in = '0;

        // Program write with bouncy press; ram_in_n must be ignored here
        prog_mode = 1'b0; addr_select = 1'b0;
        dipswitch_addr = 4'h2; dipswitch_data = 8'h3C;
        ram_in_n = 1'b0; bus_in = 8'hEE;
        p0 = pulses;
        btn(1, 1); btn(0, 1); btn(1, 1); btn(0, 1);
        btn(1, 20); btn(0, 20);
        ram_in_n = 1'b1;
        chk("prog_once", pulses - p0, 1);
        readback("prog_data", 4'h2, 8'h3C);

        // Too-short press: no write
        dipswitch_data = 8'h99;
        p0 = pulses;
        btn(1, DEB - 1); btn(0, 20);
        chk("short_press", pulses - p0, 0);
        readback("short_keep", 4'h2, 8'h3C);

        // Release bounce must not cause a second write
        dipswitch_addr = 4'h4; dipswitch_data = 8'h4D;
        p0 = pulses;
        btn(1, 12);
        btn(0, 1); btn(1, 1); btn(0, 1); btn(1, 1);
        btn(0, 20);
        chk("release_bounce", pulses - p0, 1);
        readback("release_data", 4'h4, 8'h4D);

        // Mode change while in PRESS: no write, then run-mode write to MAR address
        dipswitch_addr = 4'h6; dipswitch_data = 8'h66;
        p0 = pulses;
        btn(1, 4);
        prog_mode = 1'b1;
        btn(1, 20);
        chk("mode_abort", pulses - p0, 0);
        readback("mode_keep", 4'h6, 8'hE6);
        addr_select = 1'b1; load_mar_n = 1'b0; bus_in = 8'h08;
        tick();
        load_mar_n = 1'b1; ram_in_n = 1'b0; bus_in = 8'h11;
        tick();
        ram_in_n = 1'b1; bus_enable_n = 1'b0;
        #1;
        chk("run_write", bus_out, 8'h11);
        bus_enable_n = 1'b1;
        btn(0, 4);

        // Async reset during RELEASE with MAR = 9
        addr_select = 1'b1; load_mar_n = 1'b0; bus_in = 8'h09;
        tick();
        load_mar_n = 1'b1; bus_in = '0;
        chk("mar9", mar_q, 4'h9);
        prog_mode = 1'b0; addr_select = 1'b0;
        dipswitch_addr = 4'h7; dipswitch_data = 8'h77;
        p0 = pulses;
        btn(1, 10);
        chk("pre_rst_write", pulses - p0, 1);
        btn(0, 2);
        #2;
        clr_n = 1'b0;
        #1;
        chk("async_mar_clr", mar_q, 4'h0);
        chk("async_no_pulse", prog_write, 1'b0);
        tick(); tick();
        clr_n = 1'b1;
        btn(0, 2);
        readback("retain7", 4'h7, 8'h77);
        readback("retain2", 4'h2, 8'h3C);
        readback("retain5", 4'h5, 8'hC3);

        // Fresh press after reset is accepted (FSM back in IDLE)
        dipswitch_addr = 4'h9; dipswitch_data = 8'h9A;
        p0 = pulses;
        btn(1, 12); btn(0, 20);
        chk("post_rst_press", pulses - p0, 1);
        readback("post_rst_data", 4'h9, 8'h9A);

        // Reset mid-press with button still held: full debounce again
        dipswitch_addr = 4'hA; dipswitch_data = 8'hAB;
        btn(1, 4);
        #2;
        clr_n = 1'b0;
        tick(); tick();
        p0 = pulses;
        clr_n = 1'b1;
        start = cyc;
        for (int i = 0; i < 40 && pulses == p0; i++) tick();
        chk("held_rst_pulse", pulses - p0, 1);
        chk("held_rst_latency_ok",
            ((pulse_cyc - start) >= 2 + DEB) && ((pulse_cyc - start) <= 3 + DEB), 1);
        btn(1, 10); btn(0, 20);
        chk("held_rst_once", pulses - p0, 1);
        readback("held_rst_data", 4'hA, 8'hAB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
